// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter
//   Round-robin N-to-1 merge of the per-CPU data_cpu_to_noc streams onto a
//   single registered NoC stream. Each forwarded word carries its source CPU
//   index. The arbiter sustains one word per cycle, back-pressures every
//   loser and keeps a running count of the words it has accepted.
//
// Ports
//   clk        sole clock, all state on the rising edge
//   rstn       asynchronous active-low reset
//   in_vld     per-CPU valid (bit i = CPU i)
//   in_rdy     per-CPU ready (at most one bit high per cycle)
//   in_data    per-CPU payload, CPU i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_vld    output word valid
//   out_rdy    NoC ready
//   out_data   forwarded payload
//   out_src    index of the CPU that produced out_data
//   out_count  words accepted from the inputs since reset (wraps)
module noc_rr_arbiter #(
  parameter int NB_CPU     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int SRC_W      = $clog2(NB_CPU)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NB_CPU-1:0]            in_vld,
  output logic [NB_CPU-1:0]            in_rdy,
  input  logic [NB_CPU*DATA_WIDTH-1:0] in_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SRC_W-1:0]             out_src,
  output logic [31:0]                  out_count
);

  logic                  rdy_en;
  logic [SRC_W-1:0]      ptr;
  logic [SRC_W-1:0]      grant;
  logic                  req_any;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  accept;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [SRC_W-1:0]      src_q;
  logic [31:0]           cnt_q;

  // Reset release is synchronised through this flop: no input is granted
  // until the first rising edge after rstn deasserts.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  assign accept = !vld_q || out_rdy;

  // Search starts at ptr and wraps; the first valid requester wins.
  always_comb begin
    grant      = '0;
    req_any    = 1'b0;
    grant_data = '0;
    for (int unsigned k = 0; k < NB_CPU; k++) begin
      int unsigned idx;
      idx = k + 32'(ptr);
      if (idx >= NB_CPU) idx = idx - NB_CPU;
      if (!req_any && in_vld[idx]) begin
        req_any    = 1'b1;
        grant      = SRC_W'(idx);
        grant_data = in_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    in_rdy = '0;
    if (rdy_en && accept && req_any) in_rdy[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      src_q  <= '0;
      ptr    <= '0;
      cnt_q  <= '0;
    end else if (rdy_en && accept) begin
      if (req_any) begin
        vld_q  <= 1'b1;
        data_q <= grant_data;
        src_q  <= grant;
        ptr    <= (grant == SRC_W'(NB_CPU-1)) ? '0 : grant + 1'b1;
        cnt_q  <= cnt_q + 32'd1;
      end else begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign out_vld   = vld_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed bench for noc_rr_arbiter (NB_CPU=4, DATA_WIDTH=64).
module tb_noc_rr_arbiter;

  localparam int NB_CPU = 4;
  localparam int DW     = 64;
  localparam int SW     = 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NB_CPU-1:0]    in_vld;
  logic [NB_CPU-1:0]    in_rdy;
  logic [NB_CPU*DW-1:0] in_data;
  logic                 out_vld;
  logic                 out_rdy;
  logic [DW-1:0]        out_data;
  logic [SW-1:0]        out_src;
  logic [31:0]          out_count;

  int n_cmp = 0;
  int n_err = 0;

  noc_rr_arbiter #(.NB_CPU(NB_CPU), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int cpu, input logic [63:0] v);
    in_data[cpu*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #3;
    rstn = 1'b1;
    cyc();
  endtask

  int cnt [NB_CPU];

  initial begin
    rstn    = 1'b0;
    in_vld  = '1;
    in_data = '0;
    out_rdy = 1'b1;

    // reset held with all inputs requesting
    repeat (3) cyc();
    chk("rst_in_rdy", 64'(in_rdy), 64'h0);
    chk("rst_out_vld", 64'(out_vld), 64'h0);
    chk("rst_count", 64'(out_count), 64'h0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_src", 64'(out_src), 64'h0);

    // release: first grant goes to CPU 0
    #2 rstn = 1'b1;
    cyc();
    chk("rel_grant0", 64'(in_rdy), 64'h1);
    in_vld = '0;
    cyc();
    chk("rel_idle_vld", 64'(out_vld), 64'h0);
    chk("rel_idle_cnt", 64'(out_count), 64'h0);

    // single source on CPU 2, back-to-back
    in_vld = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      set_data(2, 64'h1000 + 64'(k));
      #1;
      chk("single_rdy", 64'(in_rdy), 64'h4);
      cyc();
      chk("single_vld", 64'(out_vld), 64'h1);
      chk("single_data", out_data, 64'h1000 + 64'(k));
      chk("single_src", 64'(out_src), 64'd2);
      chk("single_cnt", 64'(out_count), 64'(k + 1));
    end
    in_vld = '0;
    cyc();
    chk("single_drain", 64'(out_vld), 64'h0);

    // full contention from ptr=0: 0,1,2,3,... with no bubbles
    do_reset();
    for (int i = 0; i < NB_CPU; i++) cnt[i] = 0;
    in_vld = '1;
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < NB_CPU; i++) set_data(i, 64'(i * 256 + cnt[i]));
      cyc();
      chk("full_vld", 64'(out_vld), 64'h1);
      chk("full_src", 64'(out_src), 64'(j % 4));
      chk("full_data", out_data, 64'((j % 4) * 256 + j / 4));
      cnt[j % 4]++;
    end
    chk("full_cnt", 64'(out_count), 64'd40);

    // back-pressure: hold 0xDEAD from CPU 1
    in_vld = 4'b0010;
    set_data(1, 64'hDEAD);
    cyc();
    chk("bp_load_src", 64'(out_src), 64'd1);
    out_rdy = 1'b0;
    in_vld  = '1;
    for (int i = 0; i < NB_CPU; i++) set_data(i, 64'h5000 + 64'(i));
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_rdy", 64'(in_rdy), 64'h0);
      cyc();
      chk("bp_vld", 64'(out_vld), 64'h1);
      chk("bp_data", out_data, 64'hDEAD);
      chk("bp_src", 64'(out_src), 64'd1);
    end
    chk("bp_cnt", 64'(out_count), 64'd41);
    out_rdy = 1'b1;
    #1;
    chk("bp_next_rdy", 64'(in_rdy), 64'h4);
    cyc();
    chk("bp_next_src", 64'(out_src), 64'd2);
    chk("bp_next_data", out_data, 64'h5002);
    in_vld = '0;
    cyc();

    // pointer skip: bring ptr to 1, then only CPUs 0 and 3 request
    in_vld = 4'b0001;
    cyc();
    chk("skip_pre_src", 64'(out_src), 64'd0);
    in_vld = 4'b1001;
    #1;
    chk("skip_rdy1", 64'(in_rdy), 64'h8);
    cyc();
    chk("skip_src1", 64'(out_src), 64'd3);
    chk("skip_rdy2", 64'(in_rdy), 64'h1);
    cyc();
    chk("skip_src2", 64'(out_src), 64'd0);
    chk("skip_rdy3", 64'(in_rdy), 64'h8);
    cyc();
    chk("skip_src3", 64'(out_src), 64'd3);
    in_vld = '0;
    cyc();

    // counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    in_vld = 4'b0001;
    cyc();
    chk("wrap_cnt", 64'(out_count), 64'h0);
    chk("wrap_vld", 64'(out_vld), 64'h1);

    // async reset mid-stream: pending word drops without a clock edge
    in_vld = '1;
    cyc();
    chk("mid_pre_vld", 64'(out_vld), 64'h1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_vld", 64'(out_vld), 64'h0);
    chk("mid_in_rdy", 64'(in_rdy), 64'h0);
    chk("mid_cnt", 64'(out_count), 64'h0);
    cyc();
    rstn = 1'b1;
    cyc();
    chk("mid_ptr0", 64'(in_rdy), 64'h1);
    cyc();
    chk("mid_first_src", 64'(out_src), 64'd0);
    chk("mid_first_cnt", 64'(out_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // absolute time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
